// File: rtl/cla_sub_pipe.sv
// Two-stage pipelined borrow-lookahead subtractor: diff = a - b - borrow_in.
// The lower half resolves in stage 1, the upper half and flags in stage 2.
module cla_sub_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned NGRP = HALF / 4;

  // Half-width borrow-lookahead subtract; returns {borrow_out, diff}.
  function automatic logic [HALF:0] bla_sub(input logic [HALF-1:0] x,
                                            input logic [HALF-1:0] y,
                                            input logic            bin);
    logic [HALF-1:0] gb;
    logic [HALF-1:0] pb;
    logic [NGRP-1:0] gg;
    logic [NGRP-1:0] pg;
    logic [NGRP:0]   gbor;
    logic [HALF:0]   bor;
    gb   = ~x & y;
    pb   = ~(x ^ y);
    bor  = '0;
    for (int g = 0; g < int'(NGRP); g++) begin
      gg[g] = gb[4*g+3]
            | (pb[4*g+3] & gb[4*g+2])
            | (pb[4*g+3] & pb[4*g+2] & gb[4*g+1])
            | (pb[4*g+3] & pb[4*g+2] & pb[4*g+1] & gb[4*g]);
      pg[g] = &pb[4*g +: 4];
    end
    gbor[0] = bin;
    for (int g = 0; g < int'(NGRP); g++) begin
      gbor[g+1] = gg[g] | (pg[g] & gbor[g]);
    end
    // Group borrows come from the lookahead; only the bits inside a group ripple.
    for (int g = 0; g < int'(NGRP); g++) begin
      bor[4*g] = gbor[g];
      for (int k = 0; k < 3; k++) begin
        bor[4*g+k+1] = gb[4*g+k] | (pb[4*g+k] & bor[4*g+k]);
      end
    end
    bor[HALF] = gbor[NGRP];
    return {bor[HALF], x ^ y ^ bor[HALF-1:0]};
  endfunction

  logic            r_s1_valid;
  logic [HALF-1:0] r_s1_diff_lo;
  logic            r_s1_borrow;
  logic [HALF-1:0] r_s1_a_hi;
  logic [HALF-1:0] r_s1_b_hi;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;
  logic             r_overflow;
  logic             r_zero;

  logic             w_s2_accept;
  logic             w_in_ready;
  logic [HALF:0]    w_lo;
  logic [HALF:0]    w_hi;
  logic [WIDTH-1:0] w_diff_full;
  logic             w_overflow;

  assign w_s2_accept = ~r_out_valid | out_ready;
  assign w_in_ready  = ~r_s1_valid | w_s2_accept;
  assign in_ready    = w_in_ready;

  assign w_lo        = bla_sub(a[HALF-1:0], b[HALF-1:0], borrow_in);
  assign w_hi        = bla_sub(r_s1_a_hi, r_s1_b_hi, r_s1_borrow);
  assign w_diff_full = {w_hi[HALF-1:0], r_s1_diff_lo};
  assign w_overflow  = (r_s1_a_hi[HALF-1] ^ r_s1_b_hi[HALF-1]) &
                       (w_hi[HALF-1] ^ r_s1_a_hi[HALF-1]);

  // Stage 1: lower-half result plus the upper-half operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_diff_lo <= '0;
      r_s1_borrow  <= 1'b0;
      r_s1_a_hi    <= '0;
      r_s1_b_hi    <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_diff_lo <= w_lo[HALF-1:0];
        r_s1_borrow  <= w_lo[HALF];
        r_s1_a_hi    <= a[WIDTH-1:HALF];
        r_s1_b_hi    <= b[WIDTH-1:HALF];
      end
    end
  end

  // Stage 2: upper half and flags straight into the output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
      r_overflow   <= 1'b0;
      r_zero       <= 1'b0;
    end else if (w_s2_accept) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_diff       <= w_diff_full;
        r_borrow_out <= w_hi[HALF];
        r_overflow   <= w_overflow;
        r_zero       <= ~|w_diff_full;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;
  assign overflow   = r_overflow;
  assign zero       = r_zero;

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Bench for cla_sub_pipe: 8- and 16-bit instances sharing the handshake,
// checked against an arithmetic scoreboard plus directed literal vectors.
module tb_cla_sub_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned W2 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic          borrow_in;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W2-1:0] a16;
  logic [W2-1:0] b16;

  logic          in_ready, out_valid, borrow_out, overflow, zero;
  logic [W-1:0]  diff;
  logic          in_ready16, out_valid16, borrow_out16, overflow16, zero16;
  logic [W2-1:0] diff16;

  cla_sub_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .borrow_in(borrow_in), .out_valid(out_valid),
    .out_ready(out_ready), .diff(diff), .borrow_out(borrow_out),
    .overflow(overflow), .zero(zero)
  );

  cla_sub_pipe #(.WIDTH(W2)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a16), .b(b16), .borrow_in(borrow_in), .out_valid(out_valid16),
    .out_ready(out_ready), .diff(diff16), .borrow_out(borrow_out16),
    .overflow(overflow16), .zero(zero16)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  logic [34:0] q8[$];
  logic [34:0] q16[$];
  logic [W-1:0] op_a[4];
  logic [W-1:0] op_b[4];
  logic         op_c[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: {borrow_out, overflow, zero, diff} from plain integer arithmetic.
  function automatic logic [34:0] model(input int unsigned w, input logic [31:0] x,
                                        input logic [31:0] y, input logic c);
    longint      r;
    logic [31:0] d;
    logic        ov;
    r  = longint'({32'd0, x}) - longint'({32'd0, y}) - longint'({63'd0, c});
    d  = 32'(r) & 32'((64'd1 << w) - 64'd1);
    ov = (x[w-1] != y[w-1]) && (d[w-1] != x[w-1]);
    return {r < 0, ov, d == 32'd0, d};
  endfunction

  // Scoreboard: compare head every cycle output is valid, then apply handshakes.
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      q8.delete();
      q16.delete();
    end else begin
      chk("in_ready_w8_vs_w16", 32'(in_ready16), 32'(in_ready));
      if (out_valid !== 1'b0) begin
        if (q8.size() == 0) chk("unexpected_out_valid8", 32'(out_valid), 32'd0);
        else begin
          chk("sb_diff8", 32'(diff), q8[0][31:0]);
          chk("sb_borrow8", 32'(borrow_out), 32'(q8[0][34]));
          chk("sb_ovf8", 32'(overflow), 32'(q8[0][33]));
          chk("sb_zero8", 32'(zero), 32'(q8[0][32]));
          if (out_ready) void'(q8.pop_front());
        end
      end
      if (out_valid16 !== 1'b0) begin
        if (q16.size() == 0) chk("unexpected_out_valid16", 32'(out_valid16), 32'd0);
        else begin
          chk("sb_diff16", 32'(diff16), q16[0][31:0]);
          chk("sb_borrow16", 32'(borrow_out16), 32'(q16[0][34]));
          chk("sb_ovf16", 32'(overflow16), 32'(q16[0][33]));
          chk("sb_zero16", 32'(zero16), 32'(q16[0][32]));
          if (out_ready) void'(q16.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        q8.push_back(model(W, 32'(a), 32'(b), borrow_in));
        q16.push_back(model(W2, 32'(a16), 32'(b16), borrow_in));
        n_acc++;
      end
    end
  end

  task automatic load(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic c);
    a         = aa;
    b         = bb;
    borrow_in = c;
    a16       = 16'($urandom);
    b16       = ($urandom_range(0, 7) == 0) ? a16 : 16'($urandom);
  endtask

  task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic c);
    int k;
    @(posedge clk); #1;
    load(aa, bb, c);
    in_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 50);
    if (!in_ready) chk("issue_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic direct(input string nm, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic c, input logic [W-1:0] ed, input logic ebo,
                        input logic eov, input logic ez);
    issue(aa, bb, c);
    @(negedge clk);
    chk({nm, "_not_yet_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_diff"}, 32'(diff), 32'(ed));
    chk({nm, "_borrow"}, 32'(borrow_out), 32'(ebo));
    chk({nm, "_ovf"}, 32'(overflow), 32'(eov));
    chk({nm, "_zero"}, 32'(zero), 32'(ez));
  endtask

  task automatic stream(input int n);
    int idx;
    int budget;
    idx    = 0;
    budget = 0;
    @(posedge clk); #1;
    load(op_a[0], op_b[0], op_c[0]);
    in_valid = 1'b1;
    while (idx < n && budget < 200) begin
      @(negedge clk);
      budget++;
      if (in_ready) begin
        @(posedge clk); #1;
        idx++;
        if (idx < n) load(op_a[idx], op_b[idx], op_c[idx]);
        else in_valid = 1'b0;
      end
    end
    if (idx < n) begin
      chk("stream_timeout", 32'(idx), 32'(n));
      in_valid = 1'b0;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int cyc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; borrow_in = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_diff", 32'(diff), 32'd0);
    chk("reset_borrow", 32'(borrow_out), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    chk("reset_zero", 32'(zero), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    direct("sub_5a_23", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0, 1'b0);
    direct("zero_minus_bin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    direct("to_zero", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    direct("ovf_neg", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
    direct("ovf_pos", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
    direct("zero_minus_one", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);

    // Back-pressure: four ops, consumer stalled, then released.
    op_a[0] = 8'h12; op_b[0] = 8'h05; op_c[0] = 1'b0;
    op_a[1] = 8'h30; op_b[1] = 8'h31; op_c[1] = 1'b0;
    op_a[2] = 8'hF0; op_b[2] = 8'h0F; op_c[2] = 1'b1;
    op_a[3] = 8'h01; op_b[3] = 8'h01; op_c[3] = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    base = n_acc;
    fork
      stream(4);
      begin
        repeat (5) @(negedge clk);
        #1;
        chk("bp_accepted_two", 32'(n_acc - base), 32'd2);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_diff_held", 32'(diff), 32'h0D);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("bp_drain_back_to_back", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);
      end
    join

    // Reset with two ops in flight: neither may ever appear.
    op_a[0] = 8'h44; op_b[0] = 8'h11; op_c[0] = 1'b0;
    op_a[1] = 8'h09; op_b[1] = 8'h0A; op_c[1] = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    stream(2);
    chk("midflight_loaded", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_valid16", 32'(out_valid16), 32'd0);
    chk("midrst_diff", 32'(diff), 32'd0);
    chk("midrst_borrow", 32'(borrow_out), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    chk("midrst_zero", 32'(zero), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("midrst_nothing_emitted", 32'(out_valid), 32'd0);
    end

    // Full rate: one op per cycle with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      load(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      @(negedge clk);
      chk("fullrate_in_ready", 32'(in_ready), 32'd1);
      if (i >= 2) chk("fullrate_out_valid", 32'(out_valid), 32'd1);
    end

    // Random traffic with random back-pressure.
    base = n_acc;
    cyc  = 0;
    while (n_acc - base < 10000 && cyc < 40000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) begin
        a = 8'($urandom);
        load(a, a, 1'($urandom_range(0, 1)));
      end else begin
        load(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      end
      cyc++;
    end
    chk("random_ops_accepted", 32'(n_acc - base >= 10000), 32'd1);

    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while ((q8.size() != 0 || q16.size() != 0) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("final_drain8", 32'(q8.size()), 32'd0);
    chk("final_drain16", 32'(q16.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
